network_mac_pipe: RTL
=====================

Name: network_mac_pipe

Overview:
- Parametrised successor to the fixed 16s x 13ns 3-stage DSP multiplier: a pipelined fixed-point multiply-accumulate for the CNN datapath.
- Multiplies a signed activation by a weight. The weight is signed or unsigned by parameter.
- Accumulates products over a framed stream, delimited by first/last flags.
- Emits one rounded, right-shifted, saturated result per frame, with a valid strobe.
- Sits between the line buffer / weight ROM and the activation/pooling stage.

Parameters:
- A_WIDTH, 16: din0 width, always signed.
- B_WIDTH, 13: din1 width.
- B_SIGNED, 0: 1 = din1 is signed; 0 = din1 is unsigned and zero-extended by one bit.
- NUM_STAGE, 3: multiplier pipeline depth (input reg + product reg + NUM_STAGE-2 extra regs). Legal values are 2 or more.
- ACC_WIDTH, 40: accumulator width. Must be at least A_WIDTH+B_WIDTH+1.
- FRAC_SHIFT, 12: arithmetic right shift applied to the accumulator at output. Legal range is 0 to ACC_WIDTH-OUT_WIDTH.
- OUT_WIDTH, 16: signed result width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable. When low, every register holds.
- in_valid  in  1  din0/din1/in_first/in_last are valid this cycle.
- in_first  in  1  beat starts a new accumulation; accumulator loads the product instead of adding to it.
- in_last  in  1  beat ends the accumulation; a result is produced.
- din0  in  A_WIDTH  signed activation.
- din1  in  B_WIDTH  weight, signedness per B_SIGNED.
- out_valid  out  1  single-cycle (ce-qualified) result strobe.
- dout  out  OUT_WIDTH  signed result.
- ovf  out  1  result saturated; qualified by out_valid.

Behaviour:
- Reset: all pipeline registers, the accumulator, out_valid, dout and ovf clear to 0 immediately and asynchronously on reset_n low. Deassertion is sampled at clk.
- Advance rule: the pipeline advances only on cycles with ce=1. "Cycle" below means ce-qualified cycle. There is no backpressure; the consumer must sample out_valid&ce.
- Multiplier: product width is A_WIDTH+B_WIDTH+(B_SIGNED?0:1), sign-extended to ACC_WIDTH. Valid, first and last travel alongside the data in a NUM_STAGE-deep side pipeline.
- Accumulator, on product-valid:
  - first=1: acc <= prod.
  - first=0: acc <= acc+prod, wrapping modulo 2^ACC_WIDTH (sizing is the user's responsibility).
  - Product-valid without a preceding first adds onto the existing acc. This is legal and intended for bias preload chains.
- Output stage, one cycle after the accumulate of a beat with last=1:
  - r = (acc_final + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT. This is round-half-up.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. ovf=1 if clamped.
  - acc_final includes the last product; the rounding sum uses ACC_WIDTH+1 bits so it cannot wrap.
- Latency: the beat accepted with in_last at cycle t produces out_valid at t+NUM_STAGE+1. With defaults this is 4 cycles after acceptance (dout visible on the 5th edge).
- out_valid strobes high for exactly one ce-cycle. dout/ovf hold their last value between strobes.
- in_first and in_last on the same beat: single-term result.
- Back-to-back frames: a last beat followed immediately by a first beat gives full throughput, one beat per cycle, with no bubble.
- in_valid=0 beats: flags are ignored, acc holds.
- Reset mid-frame: the partial accumulation is discarded and no out_valid is issued for it.

Optional Feature:
- Macro NETWORK_MAC_RELU_EN.
- Defined: a negative r is forced to 0 before saturation; ovf reflects positive-side clamping only. This fuses the ReLU.
- Undefined: signed saturation in both directions, as specified above.

Decomposition:
- Package network_mac_pkg holds:
  - default width localparams;
  - a round_shift_sat function parametrised by widths and shift;
  - the RELU compile switch documentation constant.
- Sub-module network_mac_mul_pipe: the signed/unsigned multiplier carrying the valid/first/last side pipeline, NUM_STAGE deep. It is reusable by non-accumulating layers.

Test Plan (defaults; B unsigned, FRAC_SHIFT 12):
- Unity: din0=4096, din1=4096, first=last=1 -> out_valid exactly 4 cycles after acceptance, dout=4096, ovf=0.
- Three-term frame: (100,4096),(-50,4096),(7,4096) -> dout=57. A second frame starting the following cycle gives an independent result.
- Rounding:
  - din0=3, din1=2048 -> dout=2.
  - din0=-3, din1=2048 -> dout=-1.
- Saturation:
  - Four beats of (32767,8191) -> dout=32767, ovf=1.
  - With NETWORK_MAC_RELU_EN, (-32768,8191) -> dout=0, ovf=0.
- Stall: ce=0 for 3 cycles mid-frame -> same dout, out_valid delayed by 3 clk, and no strobe occurs during the stall.
- Reset: reset_n low for 1 cycle after the second beat of a frame -> outputs 0 immediately, no strobe for that frame, and the next frame is correct.

Source files
------------

// File: rtl/network_mac_pkg.sv
// ============================================================================
// Module   : network_mac_pkg
// Brief    : Shared widths and the round/shift/saturate helper for the CNN MAC.
//            Optional macro: NETWORK_MAC_RELU_EN (fuses ReLU into saturation).
// Revision : 1.0
// ============================================================================
`default_nettype none

package network_mac_pkg;

    localparam int DEF_A_WIDTH    = 16;
    localparam int DEF_B_WIDTH    = 13;
    localparam int DEF_B_SIGNED   = 0;
    localparam int DEF_NUM_STAGE  = 3;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_FRAC_SHIFT = 12;
    localparam int DEF_OUT_WIDTH  = 16;

    // Compile with NETWORK_MAC_RELU_EN defined to clamp negative results to zero.
`ifdef NETWORK_MAC_RELU_EN
    localparam logic RELU_ENABLED = 1'b1;
`else
    localparam logic RELU_ENABLED = 1'b0;
`endif

    localparam int RSS_W = 128;
    localparam logic signed [RSS_W-1:0] RSS_ONE = {{(RSS_W-1){1'b0}}, 1'b1};

    // Packed as {value[RSS_W-1:0], ovf}; callers truncate to {dout, ovf}.
    typedef logic [RSS_W:0] rss_t;

    function automatic rss_t round_shift_sat(
        input logic signed [RSS_W-1:0] acc,
        input int                      shift,
        input int                      out_w,
        input logic                    relu
    );
        logic signed [RSS_W-1:0] bias;
        logic signed [RSS_W-1:0] r;
        logic signed [RSS_W-1:0] hi;
        logic signed [RSS_W-1:0] lo;
        logic signed [RSS_W-1:0] sat;
        logic                    ovf;
        bias = '0;
        if (shift > 0) begin
            bias = RSS_ONE <<< (shift - 1);
        end
        r = (acc + bias) >>> shift;
        if (relu && r[RSS_W-1]) begin
            r = '0;
        end
        hi  = (RSS_ONE <<< (out_w - 1)) - RSS_ONE;
        lo  = ~hi;
        sat = r;
        ovf = 1'b0;
        if (r > hi) begin
            sat = hi;
            ovf = 1'b1;
        end else if (r < lo) begin
            sat = lo;
            ovf = 1'b1;
        end
        return {sat, ovf};
    endfunction

endpackage

`default_nettype wire

// File: rtl/network_mac_mul_pipe.sv
// ============================================================================
// Module   : network_mac_mul_pipe
// Brief    : NUM_STAGE-deep signed/unsigned multiplier with valid/first/last
//            side pipeline. Reusable by non-accumulating layers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module network_mac_mul_pipe
    import network_mac_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int B_SIGNED  = DEF_B_SIGNED,
    parameter int NUM_STAGE = DEF_NUM_STAGE,
    localparam int BE_WIDTH = B_WIDTH + ((B_SIGNED != 0) ? 0 : 1),
    localparam int PW       = A_WIDTH + BE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic signed [A_WIDTH-1:0] din0,
    input  logic        [B_WIDTH-1:0] din1,
    output logic                      prod_valid,
    output logic                      prod_first,
    output logic                      prod_last,
    output logic signed [PW-1:0]      prod
);

    localparam int EXTRA = NUM_STAGE - 2;

    logic signed [BE_WIDTH-1:0] b_ext;
    logic signed [A_WIDTH-1:0]  a_d, a_q;
    logic signed [BE_WIDTH-1:0] b_d, b_q;
    logic signed [PW-1:0]       prod2_d, prod2_q;
    // Side-band bundles are {valid, first, last}.
    logic [2:0]                 side1_d, side1_q;
    logic [2:0]                 side2_d, side2_q;
    logic [2:0]                 side_out;

    if (B_SIGNED != 0) begin : g_b_signed
        assign b_ext = din1;
    end else begin : g_b_unsigned
        assign b_ext = {1'b0, din1};
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        side1_d = side1_q;
        prod2_d = prod2_q;
        side2_d = side2_q;
        if (ce) begin
            a_d     = din0;
            b_d     = b_ext;
            side1_d = {in_valid, in_valid & in_first, in_valid & in_last};
            prod2_d = PW'(a_q) * PW'(b_q);
            side2_d = side1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            side1_q <= '0;
            prod2_q <= '0;
            side2_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            side1_q <= side1_d;
            prod2_q <= prod2_d;
            side2_q <= side2_d;
        end
    end

    if (EXTRA > 0) begin : g_extra
        logic signed [PW-1:0] pd_d [EXTRA];
        logic signed [PW-1:0] pd_q [EXTRA];
        logic [2:0]           sd_d [EXTRA];
        logic [2:0]           sd_q [EXTRA];

        always_comb begin
            for (int i = 0; i < EXTRA; i++) begin
                pd_d[i] = pd_q[i];
                sd_d[i] = sd_q[i];
            end
            if (ce) begin
                pd_d[0] = prod2_q;
                sd_d[0] = side2_q;
                for (int i = 1; i < EXTRA; i++) begin
                    pd_d[i] = pd_q[i-1];
                    sd_d[i] = sd_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < EXTRA; i++) begin
                    pd_q[i] <= '0;
                    sd_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < EXTRA; i++) begin
                    pd_q[i] <= pd_d[i];
                    sd_q[i] <= sd_d[i];
                end
            end
        end

        assign prod     = pd_q[EXTRA-1];
        assign side_out = sd_q[EXTRA-1];
    end else begin : g_no_extra
        assign prod     = prod2_q;
        assign side_out = side2_q;
    end

    assign prod_valid = side_out[2];
    assign prod_first = side_out[1];
    assign prod_last  = side_out[0];

endmodule

`default_nettype wire

// File: rtl/network_mac_pipe.sv
// ============================================================================
// Module   : network_mac_pipe
// Brief    : Pipelined framed multiply-accumulate with round/shift/saturate.
//            Optional macro: NETWORK_MAC_RELU_EN (negative results forced to 0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module network_mac_pipe
    import network_mac_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int B_WIDTH    = DEF_B_WIDTH,
    parameter int B_SIGNED   = DEF_B_SIGNED,
    parameter int NUM_STAGE  = DEF_NUM_STAGE,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [A_WIDTH-1:0]   din0,
    input  logic        [B_WIDTH-1:0]   din1,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        ovf
);

    localparam int PW = A_WIDTH + B_WIDTH + ((B_SIGNED != 0) ? 0 : 1);

    logic                        prod_valid;
    logic                        prod_first;
    logic                        prod_last;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                        fin_d, fin_q;
    logic                        out_valid_d, out_valid_q;
    logic signed [OUT_WIDTH-1:0] dout_d, dout_q;
    logic                        ovf_d, ovf_q;

    network_mac_mul_pipe #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .B_SIGNED  (B_SIGNED),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_last    (in_last),
        .din0       (din0),
        .din1       (din1),
        .prod_valid (prod_valid),
        .prod_first (prod_first),
        .prod_last  (prod_last),
        .prod       (prod)
    );

    assign prod_ext = ACC_WIDTH'(prod);

    // fin_q marks that acc_q now holds a completed frame; the output stage
    // consumes it on the next ce-cycle, so a new frame may start immediately.
    always_comb begin
        acc_d       = acc_q;
        fin_d       = fin_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        if (ce) begin
            if (prod_valid) begin
                acc_d = prod_first ? prod_ext : (acc_q + prod_ext);
            end
            fin_d       = prod_valid & prod_last;
            out_valid_d = fin_q;
            if (fin_q) begin
                {dout_d, ovf_d} = (OUT_WIDTH + 1)'(round_shift_sat(
                    RSS_W'(acc_q), FRAC_SHIFT, OUT_WIDTH, RELU_ENABLED));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            fin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fin_q       <= fin_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire
